// File: rtl/ps2_keys_pkg.sv
// Shared scan codes, field state encoding and sizing helpers for PS/2 entry fields.
package ps2_keys_pkg;

  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_BRK   = 8'hF0;
  localparam logic [7:0] KEY_BKSP  = 8'h66;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EDIT = 2'd1,
    ST_CONV = 2'd2
  } field_state_t;

  // Bits needed to hold any value of n decimal digits: clog2(10^n).
  function automatic int acc_width(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return $clog2(p);
  endfunction

  // Returns {is_digit, bcd} for a make code.
  function automatic logic [4:0] decode_digit(input logic [7:0] code);
    case (code)
      8'h45:   return 5'h10;
      8'h16:   return 5'h11;
      8'h1E:   return 5'h12;
      8'h26:   return 5'h13;
      8'h25:   return 5'h14;
      8'h2E:   return 5'h15;
      8'h36:   return 5'h16;
      8'h3D:   return 5'h17;
      8'h3E:   return 5'h18;
      8'h46:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_make_filter.sv
// Strips E0/F0 prefixes from the PS/2 byte stream and presents make codes only.
module ps2_make_filter
  import ps2_keys_pkg::*;
(
  input  logic       Clock,
  input  logic       nReset,
  input  logic       clear,
  input  logic [7:0] data,
  input  logic       data_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext
);

  logic ext_q;
  logic brk_q;
  logic is_prefix;

  assign is_prefix = (data == KEY_EXT) || (data == KEY_BRK);

  // Prefix flags: set by E0/F0, both dropped by the next real code or by clear.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (clear) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (data_en) begin
      if (data == KEY_EXT) begin
        ext_q <= 1'b1;
      end else if (data == KEY_BRK) begin
        brk_q <= 1'b1;
      end else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  assign key_valid = data_en && !clear && !is_prefix && !brk_q;
  assign key_code  = data;
  assign key_ext   = ext_q;

endmodule

// File: rtl/numeric_field_input.sv
// Decimal entry field: PS/2 digits into a BCD buffer, serial BCD-to-binary,
// range clamp and commit; arrow keys nudge the committed value directly.
module numeric_field_input
  import ps2_keys_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10,
  parameter int MIN_VAL    = 20,
  parameter int MAX_VAL    = 300,
  parameter int RESET_VAL  = 120,
  parameter int STEP       = 1
) (
  input  logic                    Clock,
  input  logic                    nReset,
  input  logic                    Enable,
  input  logic [7:0]              data,
  input  logic                    data_en,
  output logic [VALUE_W-1:0]      value,
  output logic                    value_valid,
  output logic                    range_err,
  output logic                    editing,
  output logic [4*NUM_DIGITS-1:0] digits
);

  localparam int ACC_W = acc_width(NUM_DIGITS);
  localparam int BUF_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [ACC_W-1:0]   MIN_ACC    = ACC_W'(MIN_VAL);
  localparam logic [ACC_W-1:0]   MAX_ACC    = ACC_W'(MAX_VAL);
  localparam logic [VALUE_W:0]   MAX_WIDE   = (VALUE_W+1)'(MAX_VAL);
  localparam logic [VALUE_W:0]   DOWN_FLOOR = (VALUE_W+1)'(MIN_VAL + STEP);
  localparam logic [VALUE_W-1:0] MIN_V      = VALUE_W'(MIN_VAL);
  localparam logic [VALUE_W-1:0] MAX_V      = VALUE_W'(MAX_VAL);
  localparam logic [VALUE_W-1:0] STEP_V     = VALUE_W'(STEP);

  field_state_t state_q, state_d;

  logic [BUF_W-1:0]   edit_buf_q;
  logic [CNT_W-1:0]   count_q;
  logic [IDX_W-1:0]   idx_q;
  logic [ACC_W-1:0]   acc_q;
  logic               conv_done_q;

  logic               key_valid, key_ext;
  logic [7:0]         key_code;
  logic [4:0]         dig;
  logic               is_digit, is_bksp, is_enter, is_esc, is_up, is_down;
  logic [3:0]         nibble;
  logic [ACC_W-1:0]   acc_clamped;
  logic               clamp_hit;
  logic [VALUE_W:0]   up_sum;
  logic [VALUE_W-1:0] up_next, down_next;

  // Bytes arriving while converting are discarded along with their prefix state.
  ps2_make_filter u_filter (
    .Clock     (Clock),
    .nReset    (nReset),
    .clear     (!Enable || (state_q == ST_CONV)),
    .data      (data),
    .data_en   (data_en),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ext   (key_ext)
  );

  assign dig      = decode_digit(key_code);
  assign is_digit = key_valid && !key_ext && dig[4];
  assign is_bksp  = key_valid && !key_ext && (key_code == KEY_BKSP);
  assign is_enter = key_valid && !key_ext && (key_code == KEY_ENTER);
  assign is_esc   = key_valid && !key_ext && (key_code == KEY_ESC);
  assign is_up    = key_valid &&  key_ext && (key_code == KEY_UP);
  assign is_down  = key_valid &&  key_ext && (key_code == KEY_DOWN);

  assign nibble    = edit_buf_q[4*idx_q +: 4];
  assign up_sum    = {1'b0, value} + (VALUE_W+1)'(STEP);
  assign up_next   = (up_sum > MAX_WIDE) ? MAX_V : up_sum[VALUE_W-1:0];
  assign down_next = ({1'b0, value} < DOWN_FLOOR) ? MIN_V : (value - STEP_V);

  // Clamp the converted entry into the committable range.
  always_comb begin
    acc_clamped = acc_q;
    clamp_hit   = 1'b0;
    if (acc_q < MIN_ACC) begin
      acc_clamped = MIN_ACC;
      clamp_hit   = 1'b1;
    end else if (acc_q > MAX_ACC) begin
      acc_clamped = MAX_ACC;
      clamp_hit   = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; Enable low always wins.
  always_comb begin
    state_d = state_q;
    if (!Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (is_digit) state_d = ST_EDIT;
        ST_EDIT: begin
          if (is_esc)                                state_d = ST_IDLE;
          else if (is_enter)                         state_d = ST_CONV;
          else if (is_bksp && count_q == CNT_W'(1))  state_d = ST_IDLE;
        end
        ST_CONV: if (conv_done_q) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs derived from state and edit buffer.
  always_comb begin
    editing = (state_q != ST_IDLE);
    digits  = edit_buf_q;
  end

  // Edit buffer, Horner accumulator and committed value.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      edit_buf_q  <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      conv_done_q <= 1'b0;
      value       <= VALUE_W'(RESET_VAL);
      value_valid <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      range_err   <= 1'b0;
      if (!Enable) begin
        edit_buf_q  <= '0;
        count_q     <= '0;
        conv_done_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (is_digit) begin
              edit_buf_q <= BUF_W'(dig[3:0]);
              count_q    <= CNT_W'(1);
            end else if (is_up) begin
              value       <= up_next;
              value_valid <= 1'b1;
            end else if (is_down) begin
              value       <= down_next;
              value_valid <= 1'b1;
            end
          end
          ST_EDIT: begin
            if (is_esc) begin
              edit_buf_q <= '0;
              count_q    <= '0;
            end else if (is_enter) begin
              acc_q       <= '0;
              idx_q       <= IDX_W'(NUM_DIGITS - 1);
              conv_done_q <= 1'b0;
            end else if (is_bksp) begin
              edit_buf_q <= edit_buf_q >> 4;
              count_q    <= count_q - CNT_W'(1);
            end else if (is_digit && count_q < CNT_W'(NUM_DIGITS)) begin
              edit_buf_q <= (edit_buf_q << 4) | BUF_W'(dig[3:0]);
              count_q    <= count_q + CNT_W'(1);
            end
          end
          ST_CONV: begin
            if (!conv_done_q) begin
              acc_q <= acc_q * ACC_W'(10) + ACC_W'(nibble);
              if (idx_q == '0) conv_done_q <= 1'b1;
              else             idx_q       <= idx_q - IDX_W'(1);
            end else begin
              value       <= VALUE_W'(acc_clamped);
              value_valid <= 1'b1;
              range_err   <= clamp_hit;
              edit_buf_q  <= '0;
              count_q     <= '0;
              conv_done_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_numeric_field_input.sv
// Scoreboarded bench for numeric_field_input: directed key sequences then random keys,
// checked against a digit-list reference model.
module tb_numeric_field_input;

  localparam int N     = 3;
  localparam int VW    = 10;
  localparam int MINV  = 20;
  localparam int MAXV  = 300;
  localparam int RSTV  = 120;
  localparam int STEPV = 1;

  localparam int K_DIG = 0, K_BKSP = 1, K_ENTER = 2, K_ESC = 3, K_UP = 4, K_DOWN = 5;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Enable = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          data_en = 1'b0;
  logic [VW-1:0] value;
  logic          value_valid;
  logic          range_err;
  logic          editing;
  logic [4*N-1:0] digits;

  numeric_field_input #(
    .NUM_DIGITS(N), .VALUE_W(VW), .MIN_VAL(MINV), .MAX_VAL(MAXV),
    .RESET_VAL(RSTV), .STEP(STEPV)
  ) dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .Enable      (Enable),
    .data        (data),
    .data_en     (data_en),
    .value       (value),
    .value_valid (value_valid),
    .range_err   (range_err),
    .editing     (editing),
    .digits      (digits)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int value;
    bit err;
    int edge_no;
  } exp_t;
  exp_t sb[$];

  logic [7:0] dig_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Reference model: list of typed digits plus the committed value.
  int m_digits[$];
  bit m_edit  = 1'b0;
  int m_value = RSTV;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  function automatic int packed_digits();
    int p = 0;
    foreach (m_digits[i]) p = (p << 4) | m_digits[i];
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge Clock);
    data    = b;
    data_en = 1'b1;
    @(negedge Clock);
    data_en = 1'b0;
  endtask

  // Press and release one key; the model is advanced and any expected pulse queued
  // before the make code reaches the DUT.
  task automatic do_key(input int kind, input int d);
    logic [7:0] code;
    bit ext, pulse;
    int lat, num;
    exp_t e;
    ext = 1'b0; pulse = 1'b0; lat = 0; e = '{0, 1'b0, 0};
    case (kind)
      K_DIG:   code = dig_codes[d];
      K_BKSP:  code = 8'h66;
      K_ENTER: code = 8'h5A;
      K_ESC:   code = 8'h76;
      K_UP:    begin code = 8'h75; ext = 1'b1; end
      default: begin code = 8'h72; ext = 1'b1; end
    endcase
    case (kind)
      K_DIG: begin
        if (!m_edit) begin m_digits = {d}; m_edit = 1'b1; end
        else if (m_digits.size() < N) m_digits.push_back(d);
      end
      K_BKSP: if (m_edit) begin
        void'(m_digits.pop_back());
        if (m_digits.size() == 0) m_edit = 1'b0;
      end
      K_ESC: if (m_edit) begin m_digits.delete(); m_edit = 1'b0; end
      K_ENTER: if (m_edit) begin
        num = 0;
        foreach (m_digits[i]) num = num * 10 + m_digits[i];
        e.err   = (num < MINV) || (num > MAXV);
        m_value = (num < MINV) ? MINV : (num > MAXV) ? MAXV : num;
        e.value = m_value;
        m_digits.delete();
        m_edit = 1'b0;
        pulse  = 1'b1;
        lat    = N + 1;
      end
      K_UP: if (!m_edit) begin
        m_value = (m_value + STEPV > MAXV) ? MAXV : m_value + STEPV;
        e.value = m_value; pulse = 1'b1;
      end
      default: if (!m_edit) begin
        m_value = (m_value - STEPV < MINV) ? MINV : m_value - STEPV;
        e.value = m_value; pulse = 1'b1;
      end
    endcase
    if (ext) send_byte(8'hE0);
    @(negedge Clock);
    data    = code;
    data_en = 1'b1;
    if (pulse) begin
      e.edge_no = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge Clock);
    data_en = 1'b0;
    if (ext) send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(code);
    if (kind == K_ENTER) repeat (N + 2) @(negedge Clock);
    check("editing", int'(editing), int'(m_edit));
    check("digits", int'(digits), packed_digits());
    check("value_held", int'(value), m_value);
  endtask

  task automatic type_number(input int a, input int b, input int c);
    do_key(K_DIG, a);
    do_key(K_DIG, b);
    do_key(K_DIG, c);
  endtask

  // Monitor: every value_valid pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (value_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: value_valid=1 value=%0d with no commit expected at cycle %0d",
                   value, cyc);
        end else begin
          e = sb.pop_front();
          check("commit_value", int'(value), e.value);
          check("range_err", int'(range_err), int'(e.err));
          check("pulse_edge", cyc, e.edge_no);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not complete, %0d pending expectations", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    repeat (3) @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    check("reset_value", int'(value), RSTV);
    check("reset_valid", int'(value_valid), 0);
    check("reset_range_err", int'(range_err), 0);
    check("reset_editing", int'(editing), 0);
    check("reset_digits", int'(digits), 0);

    type_number(1, 4, 5);
    do_key(K_ENTER, 0);                       // 145

    type_number(9, 9, 9);
    do_key(K_ENTER, 0);                       // 300 clamped
    do_key(K_DIG, 5);
    do_key(K_ENTER, 0);                       // 20 clamped

    type_number(1, 2, 3);
    do_key(K_DIG, 4);                         // buffer full, ignored
    check("full_buffer", int'(digits), 'h123);
    do_key(K_BKSP, 0);
    do_key(K_ENTER, 0);                       // 12 -> 20

    type_number(2, 9, 9);
    do_key(K_ENTER, 0);
    do_key(K_UP, 0);                          // 300
    do_key(K_UP, 0);                          // saturated, still pulses
    do_key(K_DOWN, 0);

    type_number(1, 5, 0);
    do_key(K_ESC, 0);

    // Enable dropped during conversion: no commit.
    do_key(K_DIG, 1);
    do_key(K_DIG, 2);
    send_byte(8'h5A);
    Enable = 1'b0;
    @(negedge Clock);
    Enable = 1'b1;
    m_digits.delete();
    m_edit = 1'b0;
    repeat (N + 3) @(negedge Clock);
    check("abort_editing", int'(editing), 0);
    check("abort_digits", int'(digits), 0);
    check("abort_value", int'(value), m_value);
    send_byte(8'hF0);
    send_byte(8'h5A);

    // Reset during conversion.
    type_number(1, 5, 0);
    send_byte(8'h5A);
    #2 nReset = 1'b0;
    #1;
    check("midconv_reset_value", int'(value), RSTV);
    check("midconv_reset_digits", int'(digits), 0);
    check("midconv_reset_editing", int'(editing), 0);
    m_value = RSTV;
    m_digits.delete();
    m_edit = 1'b0;
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    repeat (N + 3) @(negedge Clock);
    check("post_reset_value", int'(value), RSTV);

    do_key(K_ENTER, 0);                       // Enter in IDLE, no pulse
    do_key(K_BKSP, 0);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      do_key(K_DIG, $urandom_range(0, 9));
      else if (r < 12) do_key(K_BKSP, 0);
      else if (r < 15) do_key(K_ENTER, 0);
      else if (r < 16) do_key(K_ESC, 0);
      else if (r < 18) do_key(K_UP, 0);
      else             do_key(K_DOWN, 0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge Clock);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
